// File: rtl/psc_trigger_scheduler_if.sv
// Request/status bundle between a trigger scheduler and its controller.
// The master drives per-channel requests; the slave (scheduler) returns frame timing and channel status.
interface psc_trigger_scheduler_if #(
  parameter int NUM_CH  = 4,
  parameter int CNT_W   = 4,
  parameter int DELAY_W = 8
);
  logic [NUM_CH-1:0]         trigger_pulse;
  logic [NUM_CH-1:0]         enable;
  logic [NUM_CH*DELAY_W-1:0] delay_frames;
  logic [NUM_CH-1:0]         clear_overrun;
  logic [CNT_W-1:0]          tx_counter;
  logic                      tx_done;
  logic [NUM_CH-1:0]         is_trigger;
  logic [NUM_CH-1:0]         busy;
  logic [NUM_CH-1:0]         overrun;

  modport master (
    output trigger_pulse, enable, delay_frames, clear_overrun,
    input  tx_counter, tx_done, is_trigger, busy, overrun
  );

  modport slave (
    input  trigger_pulse, enable, delay_frames, clear_overrun,
    output tx_counter, tx_done, is_trigger, busy, overrun
  );
endinterface

// File: rtl/psc_trigger_scheduler.sv
// Frame-aligned multi-channel trigger scheduler: a shared frame counter plus one
// IDLE/WAIT/ACTIVE machine per channel that fires for one full frame after a programmable delay.
module psc_trigger_scheduler #(
  parameter int NUM_CH    = 4,
  parameter int FRAME_LEN = 10,
  parameter int CNT_W     = 4,
  parameter int DELAY_W   = 8
) (
  input logic                  clk,
  input logic                  reset,
  psc_trigger_scheduler_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    ACTIVE = 2'd2
  } state_e;

  logic [CNT_W-1:0]   tx_counter_q, tx_counter_d;
  state_e             state_q [NUM_CH];
  state_e             state_d [NUM_CH];
  logic [DELAY_W-1:0] dcnt_q  [NUM_CH];
  logic [DELAY_W-1:0] dcnt_d  [NUM_CH];
  logic [NUM_CH-1:0]  overrun_q, overrun_d;

  logic               tx_done_w;
  logic [NUM_CH-1:0]  is_trigger_w;
  logic [NUM_CH-1:0]  busy_w;

  // State register: frame counter, channel FSMs, delay counters and sticky flags.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_counter_q <= '0;
      overrun_q    <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= IDLE;
        dcnt_q[i]  <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values, so update order inside this block is irrelevant.
      tx_counter_q <= tx_counter_d;
      overrun_q    <= overrun_d;
      for (int i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        dcnt_q[i]  <= dcnt_d[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: every combinational output is defaulted before any branch so no path can leave it unassigned and infer a latch.
    tx_counter_d = (tx_counter_q == LAST_SLOT) ? '0 : tx_counter_q + 1'b1;
    overrun_d    = (overrun_q & ~bus.clear_overrun) | (bus.trigger_pulse & busy_w);

    for (int i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      dcnt_d[i]  = dcnt_q[i];

      unique case (state_q[i])
        IDLE: begin
          if (bus.trigger_pulse[i] && bus.enable[i]) begin
            state_d[i] = WAIT;
            dcnt_d[i]  = bus.delay_frames[i*DELAY_W +: DELAY_W];
          end
        end

        // Abort beats the frame boundary; the delay counts whole boundaries seen while waiting.
        WAIT: begin
          if (!bus.enable[i]) begin
            state_d[i] = IDLE;
          end else if (tx_done_w) begin
            if (dcnt_q[i] == '0) begin
              state_d[i] = ACTIVE;
            end else begin
              dcnt_d[i] = dcnt_q[i] - 1'b1;
            end
          end
        end

        ACTIVE: begin
          if (tx_done_w) begin
            state_d[i] = IDLE;
          end
        end

        default: begin
          state_d[i] = IDLE;
        end
      endcase
    end
  end

  // Output logic: pure decode of registered state.
  always_comb begin
    tx_done_w    = (tx_counter_q == LAST_SLOT);
    is_trigger_w = '0;
    busy_w       = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      is_trigger_w[i] = (state_q[i] == ACTIVE);
      busy_w[i]       = (state_q[i] != IDLE);
    end
  end

  assign bus.tx_counter = tx_counter_q;
  assign bus.tx_done    = tx_done_w;
  assign bus.is_trigger = is_trigger_w;
  assign bus.busy       = busy_w;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_psc_trigger_scheduler.sv
// Directed bench for psc_trigger_scheduler: a per-cycle vector table for the main scenarios,
// followed by hand-written sequences for maximum delay and asynchronous reset mid-trigger.
module tb_psc_trigger_scheduler;

  localparam int NUM_CH    = 4;
  localparam int FRAME_LEN = 10;
  localparam int CNT_W     = 4;
  localparam int DELAY_W   = 8;
  localparam int N_ROWS    = 81;

  typedef struct {
    logic [3:0]  pulse;
    logic [3:0]  en;
    logic [3:0]  clr;
    logic [31:0] dly;
    logic [3:0]  cnt;
    logic        done;
    logic [3:0]  trig;
    logic [3:0]  busy;
    logic [3:0]  ovr;
  } vec_t;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  vec_t vecs [N_ROWS];

  psc_trigger_scheduler_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .DELAY_W(DELAY_W)) bus ();

  psc_trigger_scheduler #(
    .NUM_CH   (NUM_CH),
    .FRAME_LEN(FRAME_LEN),
    .CNT_W    (CNT_W),
    .DELAY_W  (DELAY_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cnt(input logic [3:0] val, input int budget);
    int n;
    n = 0;
    while (bus.tx_counter != val && n < budget) begin
      step();
      n++;
    end
    check("wait_cnt", 32'(bus.tx_counter), 32'(val));
  endtask

  function automatic bit in_rng(input int c, input int lo, input int hi);
    return (c >= lo) && (c <= hi);
  endfunction

  initial begin
    bit bad;
    n_tests = 0;
    n_fail  = 0;

    // Row c holds the outputs expected c cycles after reset release and the inputs driven during that cycle.
    for (int c = 0; c < N_ROWS; c++) begin
      vec_t v;
      v.pulse = 4'h0;
      v.clr   = 4'h0;
      v.en    = 4'hF;
      v.dly   = (c <= 40) ? 32'h0500_0200 : 32'h0500_0000;
      case (c)
        2:  begin v.pulse = 4'b1000; v.en = 4'h7; end
        13: v.pulse = 4'b0001;
        39: v.pulse = 4'b0110;
        42: v.pulse = 4'b0001;
        45: v.pulse = 4'b0001;
        53: v.pulse = 4'b0001;
        55: begin v.pulse = 4'b0001; v.clr = 4'b0001; end
        57: v.clr = 4'b0001;
        59: v.pulse = 4'b0001;
        61: v.clr = 4'b0001;
        62: v.pulse = 4'b1000;
        66: v.en = 4'h7;
        default: ;
      endcase
      if (in_rng(c, 72, 80)) v.en[1] = 1'b0;

      v.cnt  = 4'(c % 10);
      v.done = ((c % 10) == 9);
      v.trig = {1'b0,
                in_rng(c, 50, 59),
                in_rng(c, 70, 79),
                in_rng(c, 20, 29) || in_rng(c, 50, 59)};
      v.busy = {in_rng(c, 63, 66),
                in_rng(c, 40, 59),
                in_rng(c, 40, 79),
                in_rng(c, 14, 29) || in_rng(c, 43, 59)};
      v.ovr  = {3'b000, in_rng(c, 46, 57) || in_rng(c, 60, 61)};
      vecs[c] = v;
    end

    reset             = 1'b0;
    bus.trigger_pulse = '0;
    bus.enable        = '0;
    bus.delay_frames  = '0;
    bus.clear_overrun = '0;
    step();
    step();
    check("rst tx_counter", 32'(bus.tx_counter), 32'd0);
    check("rst tx_done",    32'(bus.tx_done),    32'd0);
    check("rst is_trigger", 32'(bus.is_trigger), 32'd0);
    check("rst busy",       32'(bus.busy),       32'd0);
    check("rst overrun",    32'(bus.overrun),    32'd0);
    reset = 1'b1;

    for (int c = 0; c < N_ROWS; c++) begin
      check($sformatf("row%0d tx_counter", c), 32'(bus.tx_counter), 32'(vecs[c].cnt));
      check($sformatf("row%0d tx_done", c),    32'(bus.tx_done),    32'(vecs[c].done));
      check($sformatf("row%0d is_trigger", c), 32'(bus.is_trigger), 32'(vecs[c].trig));
      check($sformatf("row%0d busy", c),       32'(bus.busy),       32'(vecs[c].busy));
      check($sformatf("row%0d overrun", c),    32'(bus.overrun),    32'(vecs[c].ovr));
      bus.trigger_pulse = vecs[c].pulse;
      bus.enable        = vecs[c].en;
      bus.clear_overrun = vecs[c].clr;
      bus.delay_frames  = vecs[c].dly;
      step();
    end
    bus.trigger_pulse = '0;
    bus.clear_overrun = '0;
    bus.enable        = 4'hF;
    bus.delay_frames  = '0;

    // Maximum delay on ch2, accepted on a tx_done cycle; the later delay change must be ignored.
    wait_cnt(4'd9, 20);
    bus.trigger_pulse = 4'b0100;
    bus.delay_frames  = 32'h00FF_0000;
    step();
    bus.trigger_pulse = '0;
    bus.delay_frames  = '0;
    check("maxdly accept busy", 32'(bus.busy), 32'h4);
    check("maxdly accept cnt",  32'(bus.tx_counter), 32'd0);
    bad = 1'b0;
    for (int k = 0; k < 2559; k++) begin
      step();
      if (bus.is_trigger != 4'h0 || bus.busy != 4'h4) bad = 1'b1;
    end
    check("maxdly wait quiet", 32'(bad), 32'd0);
    check("maxdly last wait cnt", 32'(bus.tx_counter), 32'd9);
    step();
    check("maxdly trig rise", 32'(bus.is_trigger), 32'h4);
    check("maxdly rise cnt",  32'(bus.tx_counter), 32'd0);
    for (int k = 0; k < 9; k++) step();
    check("maxdly trig last", 32'(bus.is_trigger), 32'h4);
    step();
    check("maxdly trig fall", 32'(bus.is_trigger), 32'h0);
    check("maxdly busy fall", 32'(bus.busy), 32'h0);
    check("maxdly no overrun", 32'(bus.overrun), 32'h0);

    // Async reset at tx_counter = 6 while ch0 is ACTIVE.
    wait_cnt(4'd2, 20);
    bus.trigger_pulse = 4'b0001;
    step();
    bus.trigger_pulse = '0;
    check("arst accept busy", 32'(bus.busy), 32'h1);
    wait_cnt(4'd0, 20);
    check("arst active", 32'(bus.is_trigger), 32'h1);
    wait_cnt(4'd6, 20);
    #2;
    reset = 1'b0;
    #1;
    check("arst trig drop", 32'(bus.is_trigger), 32'h0);
    check("arst cnt drop",  32'(bus.tx_counter), 32'd0);
    check("arst busy drop", 32'(bus.busy), 32'h0);
    step();
    step();
    check("arst held cnt", 32'(bus.tx_counter), 32'd0);
    reset = 1'b1;
    step();
    check("arst first cnt", 32'(bus.tx_counter), 32'd1);
    bad = 1'b0;
    for (int k = 0; k < 12; k++) begin
      step();
      if (bus.is_trigger != 4'h0 || bus.busy != 4'h0) bad = 1'b1;
    end
    check("arst no residual", 32'(bad), 32'd0);
    check("arst cnt running", 32'(bus.tx_counter), 32'd3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/psc_trigger_scheduler.md
# psc_trigger_scheduler

Multi-channel, parametrised trigger scheduler for the power-supply controller link. A free-running frame counter divides time into TX frames of FRAME_LEN cycles. Each channel accepts a trigger pulse, waits for the next frame boundary plus a programmable number of whole frames, then asserts its trigger for exactly one full frame. With delay 0 and FRAME_LEN = 10, a single channel matches the existing single-channel trigger FSM cycle for cycle; this block adds per-channel delay, enable, busy and overrun reporting.

## Interface
- NUM_CH, 4, number of independent trigger channels (>= 1)
- FRAME_LEN, 10, cycles per TX frame (>= 2)
- CNT_W, 4, tx_counter width; must satisfy 2^CNT_W >= FRAME_LEN
- DELAY_W, 8, width of each per-channel frame-delay field
- clk  in  1  single system clock, all logic on its rising edge
- reset  in  1  asynchronous, active-low reset
- trigger_pulse  in  NUM_CH  per-channel request, one bit per channel, sampled every cycle
- enable  in  NUM_CH  per-channel enable
- delay_frames  in  NUM_CH*DELAY_W  extra whole frames to wait; channel i uses bits [i*DELAY_W +: DELAY_W]
- clear_overrun  in  NUM_CH  per-channel clear of the sticky overrun flag
- tx_counter  out  CNT_W  free-running frame slot counter
- tx_done  out  1  high while tx_counter == FRAME_LEN-1
- is_trigger  out  NUM_CH  per-channel trigger, high for one whole frame
- busy  out  NUM_CH  channel not in IDLE
- overrun  out  NUM_CH  sticky flag: a pulse arrived while the channel was busy

## Operation
- tx_counter: counts 0..FRAME_LEN-1 and wraps to 0. It is unconditional and shared by all channels. tx_done is combinational from tx_counter.
- Each channel is an independent FSM with states IDLE, WAIT and ACTIVE, plus a DELAY_W-bit down-counter dcnt.
  - IDLE: if trigger_pulse[i] & enable[i], move to WAIT and load dcnt from delay_frames[i]. delay_frames is sampled only at this point; later changes are ignored.
  - WAIT: on a tx_done cycle, if dcnt == 0 move to ACTIVE; otherwise decrement dcnt and stay. If enable[i] is low in any WAIT cycle, move to IDLE; abort takes priority over tx_done.
  - ACTIVE: is_trigger[i] = 1. On a tx_done cycle move to IDLE. Deasserting enable does not truncate ACTIVE; the frame always completes.
  - Any encoding outside the three states returns to IDLE on the next cycle.
- Output definitions:
  - is_trigger[i] = (state == ACTIVE)
  - busy[i] = (state != IDLE)
- Overrun handling:
  - trigger_pulse[i] while busy[i] is ignored (no restart, no re-queue) and sets overrun[i]. This includes a pulse on the ACTIVE-to-IDLE transition cycle.
  - A pulse while IDLE with enable low is dropped silently; no overrun.
  - clear_overrun[i] clears the flag. If a set and a clear occur in the same cycle, set wins.
- Channels never interact. Simultaneous pulses on several channels are all accepted.

## Timing
- Reset (async assert) drives every output and internal register to 0 / IDLE:
  - tx_counter = 0, tx_done = 0 (FRAME_LEN >= 2)
  - is_trigger = 0, busy = 0, overrun = 0, dcnt = 0
  - Deassertion is synchronous to clk; the counter advances on the first edge after release.
- Reset asserted mid-frame or mid-trigger: is_trigger drops immediately. No partial frame resumes.
- Acceptance latency: busy[i] rises on the first edge after the qualifying pulse cycle.
- Trigger window with delay D: is_trigger[i] covers tx_counter = 0..FRAME_LEN-1 of the frame that starts D+1 boundaries after acceptance.
  - A pulse accepted while tx_done = 1 still waits for the next full frame's boundary. It never enters ACTIVE on the immediate wrap.
- is_trigger is high for exactly FRAME_LEN cycles, aligned so that it rises when tx_counter becomes 0 and falls after tx_counter = FRAME_LEN-1.
- Minimum re-trigger spacing: a new pulse is accepted from the first cycle after ACTIVE ends, i.e. when is_trigger = 0 and busy = 0.
- dcnt = all-ones (2^DELAY_W - 1) is a legal delay with no wrap. It is loaded once and only decremented in WAIT.

## Test plan
- Reset release, no pulses:
  - tx_counter runs 0..9, 0..9 (defaults)
  - tx_done high only at count 9
  - all is_trigger/busy/overrun stay 0
- Ch0, delay 0, pulse at tx_counter = 3:
  - busy[0] rises next edge
  - is_trigger[0] high for the 10 cycles of counts 0..9 of the next frame, then busy[0] = 0
- Ch1 delay 2, ch2 delay 0, simultaneous pulses at count 9:
  - ch2 triggers on the frame after the next boundary (counts 0..9, one full frame later)
  - ch1 triggers two frames after ch2
  - no overrun
- Ch0 pulse during WAIT, then again during ACTIVE:
  - timing unchanged
  - overrun[0] = 1 and stays set
  - clear_overrun[0] together with a new pulse in ACTIVE leaves overrun[0] = 1; clear alone then returns it to 0
- Enable abort:
  - ch3 accepted with delay 5, enable[3] dropped mid-WAIT: busy[3] = 0 next edge, is_trigger[3] never asserts
  - enable dropped during ACTIVE: full 10-cycle trigger still completes
- Async reset asserted at tx_counter = 6 while ch0 is ACTIVE:
  - is_trigger[0] and tx_counter go to 0 without a clock edge
  - after release, normal operation with no residual trigger
